// File: rtl/macc_pkg.sv
// macc_pkg: width helpers, default lane typedefs and rounding shift for the multiply-accumulate pipeline
package macc_pkg;
    function automatic int prod_w(input int iw, input int qw);
        return 2 * (iw + qw);
    endfunction
    function automatic int acc_w(input int iw, input int qw, input int guard);
        return 2 * (iw + qw) + guard + 1;
    endfunction
    function automatic int out_w(input int oiw, input int oqw);
        return oiw + oqw;
    endfunction
    function automatic int rnd_shift(input int qw, input int oqw);
        return 2 * qw - oqw;
    endfunction
    localparam int IW_DEF = 8;
    localparam int QW_DEF = 8;
    localparam int OUT_IW_DEF = 12;
    localparam int OUT_QW_DEF = 8;
    localparam int GUARD_DEF = 4;
    localparam int RND_SHIFT = rnd_shift(QW_DEF, OUT_QW_DEF);
    typedef logic signed [IW_DEF+QW_DEF-1:0] lane_t;
    typedef logic signed [prod_w(IW_DEF, QW_DEF)-1:0] prod_t;
    typedef logic signed [acc_w(IW_DEF, QW_DEF, GUARD_DEF)-1:0] acc_t;
    typedef logic [out_w(OUT_IW_DEF, OUT_QW_DEF)-1:0] out_t;
endpackage

// File: rtl/macc_resize.sv
// macc_resize: round half-up and narrow one lane; MACC_SATURATE_EN clamps on overflow, otherwise wraps
module macc_resize #(
    parameter int IN_W = 37,
    parameter int SH = 8,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0] s_in,
    output logic [OUT_W-1:0]       y_out,
    output logic                   ovf_out
);
    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] HALF = (SH > 0) ? (RW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
    logic signed [RW-1:0] r;
    logic [RW-OUT_W:0] top;
    assign r = ($signed({s_in[IN_W-1], s_in}) + HALF) >>> SH;
    assign top = r[RW-1:OUT_W-1];
    assign ovf_out = !(&top || !(|top));
`ifdef MACC_SATURATE_EN
    assign y_out = ovf_out ? {r[RW-1], {(OUT_W-1){!r[RW-1]}}} : r[OUT_W-1:0];
`else
    assign y_out = r[OUT_W-1:0];
`endif
endmodule

// File: rtl/macc1d_vec_pipe.sv
// macc1d_vec_pipe: 3-stage multi-lane y = m*x + b with frame accumulate mode; overflow handling set by MACC_SATURATE_EN
module macc1d_vec_pipe
    import macc_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IW = 8,
    parameter int QW = 8,
    parameter int OUT_IW = 12,
    parameter int OUT_QW = 8,
    parameter int GUARD = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [CHANNELS*(IW+QW)-1:0]         m_in,
    input  logic [CHANNELS*(IW+QW)-1:0]         x_in,
    input  logic [CHANNELS*(IW+QW)-1:0]         b_in,
    input  logic                                acc_mode_in,
    input  logic                                last_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    output logic [CHANNELS*(OUT_IW+OUT_QW)-1:0] y_out,
    output logic [CHANNELS-1:0]                 ovf_out,
    output logic                                valid_out,
    input  logic                                ready_in
);
    localparam int DW = IW + QW;
    localparam int PW = prod_w(IW, QW);
    localparam int AW = acc_w(IW, QW, GUARD);
    localparam int OW = out_w(OUT_IW, OUT_QW);
    localparam int SH = rnd_shift(QW, OUT_QW);
    logic en, mode_eff, in_frame;
    logic s1_valid, s1_mode, s1_cont, s1_last, s2_valid;
    logic signed [PW-1:0] prod [CHANNELS];
    logic signed [PW-1:0] s1_p [CHANNELS];
    logic signed [DW-1:0] s1_b [CHANNELS];
    logic signed [AW-1:0] sum [CHANNELS];
    logic signed [AW-1:0] acc [CHANNELS];
    logic signed [AW-1:0] s2_sum [CHANNELS];
    logic [OW-1:0] res_y [CHANNELS];
    logic [CHANNELS-1:0] res_ovf;
    assign en = !valid_out || ready_in;
    assign ready_out = en;
    assign mode_eff = in_frame || acc_mode_in;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic signed [PW-1:0] m_l, x_l;
        assign m_l = PW'($signed(m_in[i*DW +: DW]));
        assign x_l = PW'($signed(x_in[i*DW +: DW]));
        assign prod[i] = m_l * x_l;
        assign sum[i] = AW'(s1_p[i]) + (s1_cont ? acc[i] : (AW'(s1_b[i]) <<< QW));
        macc_resize #(.IN_W(AW), .SH(SH), .OUT_W(OW)) u_resize (
            .s_in(s2_sum[i]),
            .y_out(res_y[i]),
            .ovf_out(res_ovf[i])
        );
    end
    // S1: register products and addends; in_frame marks an open accumulate frame
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_mode <= 1'b0;
            s1_cont <= 1'b0;
            s1_last <= 1'b0;
            in_frame <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_p[i] <= '0;
                s1_b[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= valid_in;
            s1_mode <= mode_eff;
            s1_cont <= in_frame;
            s1_last <= last_in;
            if (valid_in && mode_eff) in_frame <= !last_in;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_p[i] <= prod[i];
                s1_b[i] <= b_in[i*DW +: DW];
            end
        end
    end
    // S2: add bias or running sum; only mode-0 beats and frame-closing beats continue as valid
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                s2_sum[i] <= '0;
                acc[i] <= '0;
            end
        end else if (en) begin
            s2_valid <= s1_valid && (!s1_mode || s1_last);
            for (int i = 0; i < CHANNELS; i++) begin
                s2_sum[i] <= sum[i];
                if (s1_valid && s1_mode) acc[i] <= sum[i];
            end
        end
    end
    // S3: register rounded, narrowed lanes; held while the consumer stalls
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out <= 1'b0;
            y_out <= '0;
            ovf_out <= '0;
        end else if (en) begin
            valid_out <= s2_valid;
            ovf_out <= res_ovf;
            for (int i = 0; i < CHANNELS; i++) y_out[i*OW +: OW] <= res_y[i];
        end
    end
endmodule

// File: tb/tb_macc1d_vec_pipe.sv
// tb_macc1d_vec_pipe: randomized and directed checks of macc1d_vec_pipe against an arithmetic reference model
module tb_macc1d_vec_pipe;
    localparam int CH = 4;
    localparam int DW = 16;
    localparam int OW = 20;
    localparam int RW = CH * OW + CH;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic [CH*DW-1:0] m_in = '0, x_in = '0, b_in = '0;
    logic acc_mode_in = 1'b0, last_in = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
    logic ready_out, valid_out;
    logic [CH*OW-1:0] y_out;
    logic [CH-1:0] ovf_out;
    int n_checks = 0;
    int n_fail = 0;
    bit in_frame_m = 1'b0;
    longint acc_m [CH];
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] obs_q [$];

    macc1d_vec_pipe dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .m_in(m_in), .x_in(x_in), .b_in(b_in),
        .acc_mode_in(acc_mode_in), .last_in(last_in), .valid_in(valid_in), .ready_out(ready_out),
        .y_out(y_out), .ovf_out(ovf_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Values are in units of 2^-16; outputs in units of 2^-8 with 12 integer bits
    function automatic void model_resize(input longint s, output logic [OW-1:0] y, output logic o);
        longint t, r;
        t = s + 128;
        r = t / 256;
        if (t < 0 && t % 256 != 0) r = r - 1;
        o = (r > 524287) || (r < -524288);
`ifdef MACC_SATURATE_EN
        if (o) r = (r > 0) ? 524287 : -524288;
`endif
        y = r[OW-1:0];
    endfunction

    function automatic void model_accept();
        bit mode;
        longint p, s;
        logic [OW-1:0] yl;
        logic ol;
        logic [CH*OW-1:0] y;
        logic [CH-1:0] o;
        mode = in_frame_m || acc_mode_in;
        for (int l = 0; l < CH; l++) begin
            p = sx(m_in[l*DW +: DW]) * sx(x_in[l*DW +: DW]);
            s = (mode && in_frame_m) ? p + acc_m[l] : p + sx(b_in[l*DW +: DW]) * 256;
            if (mode) acc_m[l] = s;
            model_resize(s, yl, ol);
            y[l*OW +: OW] = yl;
            o[l] = ol;
        end
        if (!mode || last_in) exp_q.push_back({o, y});
        if (mode) in_frame_m = !last_in;
    endfunction

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (valid_in && ready_out) model_accept();
            if (valid_out && ready_in) obs_q.push_back({ovf_out, y_out});
        end
    end

    function automatic logic [CH*DW-1:0] rnd_vec();
        logic [CH*DW-1:0] v;
        for (int l = 0; l < CH; l++)
            v[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2047)) - 16'd1024;
        return v;
    endfunction

    task automatic send(input logic [CH*DW-1:0] m, input logic [CH*DW-1:0] x, input logic [CH*DW-1:0] b,
                        input logic mode, input logic last);
        int t = 0;
        m_in = m; x_in = x; b_in = b; acc_mode_in = mode; last_in = last; valid_in = 1'b1;
        forever begin
            @(negedge clk_in);
            if (ready_out) break;
            t++;
            if (t > 50) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: ready_out low for %0d cycles, required 1", t);
                break;
            end
        end
        @(posedge clk_in); #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 100) begin
            @(posedge clk_in); #1;
            t++;
        end
        repeat (4) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid_out); end
        n_checks++; if (y_out !== '0) begin n_fail++; $display("FAIL reset_y: got %h, expected 0", y_out); end
        n_checks++; if (ovf_out !== '0) begin n_fail++; $display("FAIL reset_ovf: got %h, expected 0", ovf_out); end
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", ready_out); end
    endtask

    task automatic test_mode0();
        int lat = 1;
        send({CH{16'h0180}}, {CH{16'h0200}}, {CH{16'h0040}}, 1'b0, 1'b1);
        while (lat < 10) begin
            @(posedge clk_in); #1;
            lat++;
            if (valid_out) break;
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mode0_latency: got %0d, expected 3", lat); end
        n_checks++; if (y_out !== {CH{20'd832}} || ovf_out !== '0) begin n_fail++; $display("FAIL mode0_directed: got %h/%h, expected %h/0", y_out, ovf_out, {CH{20'd832}}); end
        for (int k = 0; k < 8; k++) send(rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 1'($urandom_range(0, 1)));
        drain();
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mode0_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL mode0_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_accum();
        for (int k = 1; k <= 4; k++) begin
            send({CH{16'h0100}}, {CH{16'(k * 256)}}, (k == 1) ? {CH{16'h0080}} : rnd_vec(), (k == 1), (k == 4));
            if (k < 4) begin
                n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL accum_bubble%0d: got %b, expected 0", k, valid_out); end
            end
        end
        drain();
        n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL accum_count: got %0d, expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== {4'h0, {CH{20'd2688}}}) begin n_fail++; $display("FAIL accum_value: got %h, expected %h", obs_q[0], {4'h0, {CH{20'd2688}}}); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [OW-1:0] ey;
`ifdef MACC_SATURATE_EN
        ey = 20'h7FFFF;
`else
        ey = 20'hF8000;
`endif
        send({CH{16'h7F00}}, {CH{16'h7F00}}, {CH{16'h7F00}}, 1'b0, 1'b0);
        send({CH{16'h8000}}, {CH{16'h7F00}}, {CH{16'h8000}}, 1'b0, 1'b0);
        drain();
        n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL ovf_count: got %0d, expected 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            n_checks++; if (obs_q[0] !== {4'hF, {CH{ey}}}) begin n_fail++; $display("FAIL ovf_pos: got %h, expected %h", obs_q[0], {4'hF, {CH{ey}}}); end
            n_checks++; if (obs_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL ovf_neg: got %h, expected %h", obs_q[1], exp_q[1]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_rounding();
        logic [RW-1:0] ev;
        ev = {4'h0, 20'd2, 20'hFFFFF, 20'd0, 20'd1};
        send({16'h0003, 16'hFFFF, 16'hFFFF, 16'h0001}, {16'h0080, 16'h0180, 16'h0080, 16'h0080}, '0, 1'b0, 1'b0);
        drain();
        n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL round_count: got %0d, expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== ev) begin n_fail++; $display("FAIL round_half_up: got %h, expected %h", obs_q[0], ev); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [CH*OW-1:0] y0;
        logic [CH-1:0] o0;
        fork
            for (int k = 0; k < 12; k++) send(rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk_in);
                #1;
                ready_in = 1'b0;
                #1;
                y0 = y_out; o0 = ovf_out;
                for (int c = 0; c < 5; c++) begin
                    n_checks++; if (ready_out !== 1'b0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_ready%0d: got ready %b valid %b, expected 0 1", c, ready_out, valid_out); end
                    n_checks++; if (y_out !== y0 || ovf_out !== o0) begin n_fail++; $display("FAIL stall_hold%0d: got %h, expected %h", c, y_out, y0); end
                    @(posedge clk_in); #1;
                end
                ready_in = 1'b1;
            end
        join
        drain();
        n_checks++; if (obs_q.size() !== 12 || exp_q.size() !== 12) begin n_fail++; $display("FAIL bp_count: got %0d, expected 12", obs_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        send({CH{16'h0300}}, {CH{16'h0500}}, {CH{16'h0100}}, 1'b1, 1'b0);
        send({CH{16'h0200}}, {CH{16'h0700}}, '0, 1'b1, 1'b0);
        rst_n_in = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0 || y_out !== '0 || ovf_out !== '0) begin n_fail++; $display("FAIL midreset_clear: got %b %h %h, expected 0 0 0", valid_out, y_out, ovf_out); end
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        in_frame_m = 1'b0;
        obs_q.delete(); exp_q.delete();
        send({CH{16'h0100}}, {CH{16'h0100}}, '0, 1'b1, 1'b1);
        drain();
        n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL midreset_count: got %0d, expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== {4'h0, {CH{20'd256}}}) begin n_fail++; $display("FAIL midreset_value: got %h, expected %h", obs_q[0], {4'h0, {CH{20'd256}}}); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                int flen = 0;
                logic mode, last;
                for (int k = 0; k < 150; k++) begin
                    mode = 1'($urandom_range(0, 1));
                    last = ($urandom_range(0, 3) == 0) || flen >= 10;
                    if ((in_frame_m || mode) && !last) flen++;
                    else flen = 0;
                    send(rnd_vec(), rnd_vec(), rnd_vec(), mode, last);
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk_in); #1; end
                end
                if (in_frame_m) send(rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 1'b1);
                done = 1'b1;
            end
            while (!done) begin
                ready_in = ($urandom_range(0, 2) != 0);
                @(posedge clk_in); #1;
            end
        join
        ready_in = 1'b1;
        drain();
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_checks++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_beat%0d: got %h, expected %h", k, obs_q[k], exp_q[k]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int l = 0; l < CH; l++) acc_m[l] = 0;
        test_reset();
        test_mode0();
        test_accum();
        test_overflow();
        test_rounding();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
